// File: rtl/fetch_stage.sv
// Instruction-fetch stage and F/D pipeline register: owns PCF, issues imem reads
// (at most one outstanding), holds one response in a skid slot while decode is stalled.
module fetch_stage #(
    parameter int                        ADDRESS_WIDTH = 32,
    parameter int                        DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0,
    parameter logic [DATA_WIDTH-1:0]     NOP_INSTR     = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     StallF,
    input  logic                     StallD,
    input  logic                     FlushD,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_rvalid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [ADDRESS_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0]    InstrD,
    output logic [ADDRESS_WIDTH-1:0] PCD,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
    output logic                     ValidD
);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t                   state, state_next;
    logic [ADDRESS_WIDTH-1:0] req_pc;
    logic                     skid_valid;
    logic [DATA_WIDTH-1:0]    skid_instr;
    logic [ADDRESS_WIDTH-1:0] skid_pc;

    logic                     resp;
    logic                     deliver;
    logic                     issue;
    logic [ADDRESS_WIDTH-1:0] target;
    logic [ADDRESS_WIDTH-1:0] load_pc;
    logic [DATA_WIDTH-1:0]    load_instr;

    assign resp   = (state == WAIT) && imem_rvalid;
    // A redirect kills both the in-flight response and the skid entry: both are wrong-path.
    assign deliver = (resp || skid_valid) && !PCSrcE;
    assign issue  = rst_n && !PCSrcE && !StallF && !skid_valid && !(resp && StallD) &&
                    ((state == IDLE) || resp);
    assign target = PCTargetE & ~ADDRESS_WIDTH'(3);

    assign load_pc    = skid_valid ? skid_pc    : req_pc;
    assign load_instr = skid_valid ? skid_instr : imem_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (issue) state_next = WAIT;
            WAIT: begin
                if (PCSrcE)           state_next = imem_rvalid ? IDLE : DISCARD;
                else if (imem_rvalid) state_next = issue ? WAIT : IDLE;
            end
            DISCARD: if (imem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request outputs
    always_comb begin
        imem_req  = issue;
        imem_addr = PCF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PCF    <= RESET_PC;
            req_pc <= '0;
        end else if (PCSrcE) begin
            PCF    <= target;
        end else if (issue) begin
            PCF    <= PCF + ADDRESS_WIDTH'(4);
            req_pc <= PCF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
        end else if (FlushD || PCSrcE) begin
            skid_valid <= 1'b0;
        end else if (StallD) begin
            if (resp) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc    <= req_pc;
            end
        end else if (skid_valid) begin
            skid_valid <= 1'b0;
        end
    end

    // F/D register: flush beats stall beats load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (FlushD) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
        end else if (!StallD) begin
            if (deliver) begin
                ValidD   <= 1'b1;
                InstrD   <= load_instr;
                PCD      <= load_pc;
                PCPlus4D <= load_pc + ADDRESS_WIDTH'(4);
            end else begin
                ValidD   <= 1'b0;
                InstrD   <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural fixed-latency instruction memory
// returning rdata = addr | 1.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PCF(PCF), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    // Memory: response shows up 'lat' cycles after the request cycle.
    always @(negedge clk) begin
        if (pend && cnt == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = paddr | 32'h1;
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (pend) cnt = cnt - 1;
        end
        #1;
        if (imem_req === 1'b1) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = imem_addr;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic pc, input logic [31:0] tgt);
        @(negedge clk);
        rst_n = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = pc; PCTargetE = tgt;
        #2;
    endtask

    task automatic do_reset(input int l);
        lat = l;
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("reset req",    imem_req, 32'h0);
        chk("reset ValidD", ValidD,   32'h0);
        chk("reset InstrD", InstrD,   32'h13);
        chk("reset PCD",    PCD,      32'h0);
        chk("reset PCP4D",  PCPlus4D, 32'h0);
        chk("reset PCF",    PCF,      32'h0);
    endtask

    typedef struct {
        logic        sd;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_v;
        logic [31:0] exp_pcd;
        logic [31:0] exp_instr;
        logic [31:0] exp_p4;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n, req_n;
        bit found;

        // Streaming at latency 1, then a 3-cycle decode stall as the 0x8 response lands.
        tbl[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 32'h13, 32'h00};
        tbl[1] = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0, 32'h13, 32'h00};
        tbl[2] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0, 32'h01, 32'h04};
        tbl[3] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h4, 32'h05, 32'h08};
        tbl[4] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h4, 32'h05, 32'h08};
        tbl[5] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h4, 32'h05, 32'h08};
        tbl[6] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h4, 32'h05, 32'h08};
        tbl[7] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h8, 32'h09, 32'h0C};
        tbl[8] = '{1'b0, 1'b1, 32'h10, 1'b0, 32'h8, 32'h13, 32'h0C};
        tbl[9] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'hC, 32'h0D, 32'h10};

        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, tbl[i].sd, 1'b0, 1'b0, 32'h0);
            chk($sformatf("tbl%0d req", i), imem_req, tbl[i].exp_req);
            if (tbl[i].exp_req) chk($sformatf("tbl%0d addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d ValidD", i), ValidD,   tbl[i].exp_v);
            chk($sformatf("tbl%0d PCD", i),    PCD,      tbl[i].exp_pcd);
            chk($sformatf("tbl%0d InstrD", i), InstrD,   tbl[i].exp_instr);
            chk($sformatf("tbl%0d PCP4D", i),  PCPlus4D, tbl[i].exp_p4);
        end

        // Redirect while waiting on a latency-3 fetch of 0x10.
        do_reset(3);
        n = 0; found = 1'b0;
        while (!found && n < 40) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            n++;
            if (imem_req && imem_addr == 32'h10) found = 1'b1;
        end
        chk("t3 reach 0x10", 32'(found), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h103);
        chk("t3 req on redirect", imem_req, 32'h0);
        n = 0; req_n = 0; found = 1'b0;
        while (!found && n < 30) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            n++;
            if (n == 1) chk("t3 PCF", PCF, 32'h100);
            if (imem_req && req_n == 0) begin
                req_n = n;
                chk("t3 reissue addr", imem_addr, 32'h100);
            end
            if (ValidD) found = 1'b1;
        end
        chk("t3 reissue step", req_n, 32'd3);
        chk("t3 ValidD seen", 32'(found), 32'h1);
        chk("t3 PCD", PCD, 32'h100);
        chk("t3 InstrD", InstrD, 32'h101);

        // Redirect in the same cycle as the response.
        do_reset(1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4 s0 addr", imem_addr, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        chk("t4 s1 req", imem_req, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4 s2 ValidD", ValidD, 32'h0);
        chk("t4 s2 req", imem_req, 32'h1);
        chk("t4 s2 addr", imem_addr, 32'h200);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4 s3 ValidD", ValidD, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4 s4 ValidD", ValidD, 32'h1);
        chk("t4 s4 PCD", PCD, 32'h200);
        chk("t4 s4 InstrD", InstrD, 32'h201);
        chk("t4 s4 PCP4D", PCPlus4D, 32'h204);

        // FlushD together with StallD empties the skid slot.
        do_reset(1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t5 s2 ValidD", ValidD, 32'h1);
        chk("t5 s2 req", imem_req, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t5 s3 req", imem_req, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t5 s4 ValidD", ValidD, 32'h0);
        chk("t5 s4 InstrD", InstrD, 32'h13);
        chk("t5 s4 PCD", PCD, 32'h0);
        chk("t5 s4 req", imem_req, 32'h1);
        chk("t5 s4 addr", imem_addr, 32'h8);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t5 s5 ValidD", ValidD, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t5 s6 ValidD", ValidD, 32'h1);
        chk("t5 s6 PCD", PCD, 32'h8);
        chk("t5 s6 InstrD", InstrD, 32'h9);

        // Reset pulse while a latency-2 fetch is outstanding.
        do_reset(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6 s0 req", imem_req, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6 s1 req", imem_req, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6 s2 ValidD", ValidD, 32'h0);
        chk("t6 s2 req", imem_req, 32'h1);
        chk("t6 s2 addr", imem_addr, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6 s3 ValidD", ValidD, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6 s4 ValidD", ValidD, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6 s5 ValidD", ValidD, 32'h1);
        chk("t6 s5 PCD", PCD, 32'h0);
        chk("t6 s5 InstrD", InstrD, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
